// File: rtl/multi_cycle_ctrl_if.sv
// Control bus between the multi-cycle controller and the datapath.
// The datapath (master) supplies instruction fields and the zero flag; the controller (slave) returns enables.
interface multi_cycle_ctrl_if #(
   parameter int ST_W = 4
);
   logic [5:0]      Op;
   logic [5:0]      Funct;
   logic            Zero;
   logic            PCWr;
   logic            IRWr;
   logic            RFWr;
   logic            DMWr;
   logic [1:0]      ExtOp;
   logic [2:0]      ALUOp;
   logic            BSel;
   logic [1:0]      WDSel;
   logic [1:0]      GPRSel;
   logic [1:0]      NPCOp;
   logic [ST_W-1:0] state;
   logic            instr_done;
   logic            illegal;

   modport master (
      output Op, Funct, Zero,
      input  PCWr, IRWr, RFWr, DMWr, ExtOp, ALUOp, BSel, WDSel, GPRSel, NPCOp,
      input  state, instr_done, illegal
   );

   modport slave (
      input  Op, Funct, Zero,
      output PCWr, IRWr, RFWr, DMWr, ExtOp, ALUOp, BSel, WDSel, GPRSel, NPCOp,
      output state, instr_done, illegal
   );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset controller: Moore FSM over state and opcode, Zero used only in BR.
// All outputs are forced low while rstn is low, independent of the clock.
module multi_cycle_ctrl #(
   parameter int ST_W = 4
) (
   input logic                clk,
   input logic                rstn,
   multi_cycle_ctrl_if.slave  bus
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DCD = 4'd1, EXE = 4'd2, MADR = 4'd3, MRD = 4'd4,
      MWB   = 4'd5, MWR = 4'd6, AWB = 4'd7, BR   = 4'd8, JMP = 4'd9
   } state_t;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;

   state_t     state_q, state_d;
   logic [5:0] op_q, funct_q;
   logic [5:0] cur_op, cur_funct;
   logic       is_rtype, funct_ok, is_alu_i, is_mem, is_jump;
   logic [1:0] ext_op;

   logic       pc_wr, ir_wr, rf_wr, dm_wr, b_sel, done, ill;
   logic [1:0] ext_sel, wd_sel, gpr_sel, npc_op;
   logic [2:0] alu_op;

   // The decoded fields are captured on the DCD edge so later opcode churn cannot redirect the sequence.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= FETCH;
         op_q    <= 6'd0;
         funct_q <= 6'd0;
      end else begin
         state_q <= state_d;
         if (state_q == DCD) begin
            op_q    <= bus.Op;
            funct_q <= bus.Funct;
         end
      end
   end

   always_comb begin
      cur_op    = (state_q == DCD) ? bus.Op    : op_q;
      cur_funct = (state_q == DCD) ? bus.Funct : funct_q;
      is_rtype  = (cur_op == OP_R);
      funct_ok  = (cur_funct inside {F_ADDU, F_SUBU, F_AND, F_OR, F_SLT});
      is_alu_i  = (cur_op inside {OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI});
      is_mem    = (cur_op inside {OP_LW, OP_SW});
      is_jump   = (cur_op inside {OP_J, OP_JAL});
      case (cur_op)
         OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ: ext_op = 2'b01;
         OP_LUI:                                  ext_op = 2'b10;
         default:                                 ext_op = 2'b00;
      endcase
   end

   always_comb begin
      state_d = FETCH;
      pc_wr   = 1'b0;
      ir_wr   = 1'b0;
      rf_wr   = 1'b0;
      dm_wr   = 1'b0;
      b_sel   = 1'b0;
      done    = 1'b0;
      ill     = 1'b0;
      ext_sel = 2'b00;
      wd_sel  = 2'b00;
      gpr_sel = 2'b00;
      npc_op  = 2'b00;
      alu_op  = 3'b000;
      if (state_q inside {DCD, EXE, MADR, MRD, MWB, MWR, AWB, BR, JMP}) ext_sel = ext_op;
      case (state_q)
         FETCH: begin
            ir_wr   = 1'b1;
            pc_wr   = 1'b1;
            state_d = DCD;
         end
         DCD: begin
            if ((is_rtype && funct_ok) || is_alu_i) state_d = EXE;
            else if (is_mem)                        state_d = MADR;
            else if (cur_op == OP_BEQ)              state_d = BR;
            else if (is_jump)                       state_d = JMP;
            else                                    ill     = 1'b1;
         end
         EXE: begin
            b_sel = !is_rtype;
            if (is_rtype) begin
               case (cur_funct)
                  F_SUBU:  alu_op = 3'b001;
                  F_AND:   alu_op = 3'b010;
                  F_OR:    alu_op = 3'b011;
                  F_SLT:   alu_op = 3'b100;
                  default: alu_op = 3'b000;
               endcase
            end else if (cur_op == OP_ORI) begin
               alu_op = 3'b011;
            end
            state_d = AWB;
         end
         MADR: begin
            b_sel   = 1'b1;
            state_d = (cur_op == OP_LW) ? MRD : MWR;
         end
         MRD: state_d = MWB;
         MWB: begin
            rf_wr   = 1'b1;
            wd_sel  = 2'b01;
            gpr_sel = 2'b01;
            done    = 1'b1;
         end
         MWR: begin
            dm_wr = 1'b1;
            done  = 1'b1;
         end
         AWB: begin
            rf_wr   = 1'b1;
            gpr_sel = is_rtype ? 2'b00 : 2'b01;
            done    = 1'b1;
         end
         BR: begin
            alu_op = 3'b001;
            npc_op = 2'b01;
            pc_wr  = bus.Zero;
            done   = 1'b1;
         end
         JMP: begin
            pc_wr  = 1'b1;
            npc_op = 2'b10;
            if (cur_op == OP_JAL) begin
               rf_wr   = 1'b1;
               wd_sel  = 2'b10;
               gpr_sel = 2'b10;
            end
            done = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

   // Reset gating is combinational so enables drop the moment rstn falls.
   assign bus.PCWr       = rstn & pc_wr;
   assign bus.IRWr       = rstn & ir_wr;
   assign bus.RFWr       = rstn & rf_wr;
   assign bus.DMWr       = rstn & dm_wr;
   assign bus.BSel       = rstn & b_sel;
   assign bus.instr_done = rstn & done;
   assign bus.illegal    = rstn & ill;
   assign bus.ExtOp      = rstn ? ext_sel : 2'b00;
   assign bus.ALUOp      = rstn ? alu_op  : 3'b000;
   assign bus.WDSel      = rstn ? wd_sel  : 2'b00;
   assign bus.GPRSel     = rstn ? gpr_sel : 2'b00;
   assign bus.NPCOp      = rstn ? npc_op  : 2'b00;
   assign bus.state      = ST_W'(state_q);
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized scoreboard bench for multi_cycle_ctrl: an instruction-level model queues the
// expected per-cycle control word; a negedge monitor compares what the controller presents.
module tb_multi_cycle_ctrl;
   localparam int ST_W = 4;
   localparam int W    = 22;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   multi_cycle_ctrl_if #(.ST_W(ST_W)) bus ();
   multi_cycle_ctrl #(.ST_W(ST_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   logic [W-1:0] exp_q[$];
   logic [W-1:0] msk_q[$];
   int total = 0;
   int bad   = 0;
   logic mon_on = 1'b0;
   logic [5:0] ops[10] = '{6'b000000, 6'b001000, 6'b001001, 6'b001101, 6'b001111,
                           6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
   logic [5:0] functs[5] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};

   // {state, PCWr, IRWr, RFWr, DMWr, ExtOp, ALUOp, BSel, WDSel, GPRSel, NPCOp, instr_done, illegal}
   function automatic logic [W-1:0] obs_vec();
      return {4'(bus.state), bus.PCWr, bus.IRWr, bus.RFWr, bus.DMWr, bus.ExtOp, bus.ALUOp,
              bus.BSel, bus.WDSel, bus.GPRSel, bus.NPCOp, bus.instr_done, bus.illegal};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Reference: instruction class -> state walk -> per-state control values.
   task automatic push_instr(input logic [5:0] op, input logic [5:0] funct,
                             input logic zero, output int n);
      int seq[$];
      int s;
      logic bad_i, jal, rt;
      logic pc, ir, rf, dm, bs, dn, il;
      logic [1:0] ext, wd, gp, np;
      logic [2:0] alu;
      logic m_alu, m_wd, m_np, m_dn;
      rt    = (op == 6'b000000);
      jal   = (op == 6'b000011);
      bad_i = 1'b0;
      if (rt) begin
         bad_i = !(funct inside {6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010});
         seq   = bad_i ? '{0, 1} : '{0, 1, 2, 7};
      end else if (op inside {6'b001000, 6'b001001, 6'b001101, 6'b001111}) seq = '{0, 1, 2, 7};
      else if (op == 6'b100011)                                             seq = '{0, 1, 3, 4, 5};
      else if (op == 6'b101011)                                             seq = '{0, 1, 3, 6};
      else if (op == 6'b000100)                                             seq = '{0, 1, 8};
      else if (op inside {6'b000010, 6'b000011})                            seq = '{0, 1, 9};
      else begin
         bad_i = 1'b1;
         seq   = '{0, 1};
      end
      if (op inside {6'b001000, 6'b001001, 6'b100011, 6'b101011, 6'b000100}) ext = 2'b01;
      else if (op == 6'b001111) ext = 2'b10;
      else                      ext = 2'b00;
      n = seq.size();
      foreach (seq[i]) begin
         s   = seq[i];
         ir  = (s == 0);
         pc  = (s == 0) || (s == 9) || (s == 8 && zero);
         rf  = (s == 7) || (s == 5) || (s == 9 && jal);
         dm  = (s == 6);
         il  = (s == 1) && bad_i;
         dn  = (i == n - 1) && !bad_i;
         m_dn = !bad_i;
         alu = 3'b000; bs = 1'b0; wd = 2'b00; gp = 2'b00; np = 2'b00;
         m_alu = (s == 2) || (s == 3) || (s == 8);
         m_wd  = (s == 7) || (s == 5) || (s == 9 && jal);
         m_np  = (s == 0) || (s == 8) || (s == 9);
         if (s == 2) begin
            bs = !rt;
            if (rt) begin
               case (funct)
                  6'b100011: alu = 3'b001;
                  6'b100100: alu = 3'b010;
                  6'b100101: alu = 3'b011;
                  6'b101010: alu = 3'b100;
                  default:   alu = 3'b000;
               endcase
            end else if (op == 6'b001101) alu = 3'b011;
         end
         if (s == 3) bs = 1'b1;
         if (s == 8) begin alu = 3'b001; np = 2'b01; end
         if (s == 9) np = 2'b10;
         if (s == 7) gp = rt ? 2'b00 : 2'b01;
         if (s == 5) begin wd = 2'b01; gp = 2'b01; end
         if (s == 9 && jal) begin wd = 2'b10; gp = 2'b10; end
         exp_q.push_back({4'(s), pc, ir, rf, dm, (s == 0) ? 2'b00 : ext, alu, bs, wd, gp, np, dn, il});
         msk_q.push_back({4'hF, 4'hF, 2'b11, m_alu ? 4'hF : 4'h0, m_wd ? 4'hF : 4'h0,
                          m_np ? 2'b11 : 2'b00, m_dn, 1'b1});
      end
   endtask

   // Issue one instruction at the start of its FETCH cycle and return at the start of the next.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                            input logic zero, input logic scramble);
      int n;
      bus.Op    = op;
      bus.Funct = funct;
      bus.Zero  = zero;
      push_instr(op, funct, zero, n);
      for (int c = 1; c <= n; c++) begin
         @(posedge clk);
         #1;
         if (scramble && c == 3 && n > 3) begin
            bus.Op    = 6'($urandom);
            bus.Funct = 6'($urandom);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_cycle: got %h expected nothing queued", obs_vec());
         end else begin
            logic [W-1:0] e, m;
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            check("cycle", obs_vec() & m, e & m);
         end
      end
   end

   initial begin
      int k;
      logic [5:0] op, fn;
      bus.Op    = 6'd0;
      bus.Funct = 6'd0;
      bus.Zero  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", obs_vec(), '0);
      rstn   = 1'b1;
      mon_on = 1'b1;

      run_instr(6'b000000, 6'b100001, 1'b0, 1'b0);
      run_instr(6'b001101, 6'b000000, 1'b0, 1'b0);
      run_instr(6'b001111, 6'b000000, 1'b0, 1'b0);
      run_instr(6'b100011, 6'b000000, 1'b0, 1'b0);
      run_instr(6'b000100, 6'b000000, 1'b1, 1'b0);
      run_instr(6'b000100, 6'b000000, 1'b0, 1'b0);
      run_instr(6'b000011, 6'b000000, 1'b0, 1'b0);
      run_instr(6'b111111, 6'b000000, 1'b0, 1'b0);
      run_instr(6'b000000, 6'b111111, 1'b0, 1'b0);
      run_instr(6'b101011, 6'b000000, 1'b0, 1'b0);
      run_instr(6'b000010, 6'b000000, 1'b1, 1'b0);

      for (int i = 0; i < 200; i++) begin
         k  = $urandom_range(0, 11);
         op = (k < 10) ? ops[k] : 6'($urandom);
         fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : functs[$urandom_range(0, 4)];
         run_instr(op, fn, 1'($urandom), 1'($urandom));
      end

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      // Abort a store while it is in MWR.
      bus.Op = 6'b101011;
      push_instr(6'b101011, 6'b000000, 1'b0, k);
      repeat (3) @(posedge clk);
      #1;
      mon_on = 1'b0;
      exp_q.delete();
      msk_q.delete();
      check("sw_in_mwr", {28'(bus.state), 3'b000, bus.DMWr}, {28'd6, 3'b000, 1'b1});
      #1 rstn = 1'b0;
      #1;
      check("async_reset_mwr", obs_vec(), '0);
      @(posedge clk);
      #1;
      check("reset_hold", obs_vec(), '0);
      rstn   = 1'b1;
      mon_on = 1'b1;
      run_instr(6'b001000, 6'b000000, 1'b0, 1'b0);
      mon_on = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have parameter ST_W, default 4, state register width.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port Op  input  6  instruction opcode field, taken from the instruction register.
REQ-005 The block SHALL have port Funct  input  6  R-type function field.
REQ-006 The block SHALL have port Zero  input  1  ALU zero flag.
REQ-007 The block SHALL have port PCWr  output  1  PC write enable.
REQ-008 The block SHALL have port IRWr  output  1  instruction register write enable.
REQ-009 The block SHALL have port RFWr  output  1  register file write enable.
REQ-010 The block SHALL have port DMWr  output  1  data memory write enable.
REQ-011 The block SHALL have port ExtOp  output  2  immediate extender control: 00 zero-extend, 01 sign-extend, 10 high-position (imm in bits 31:16).
REQ-012 The block SHALL have port ALUOp  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-013 The block SHALL have port BSel  output  1  ALU B operand select: 0 register, 1 Imm32.
REQ-014 The block SHALL have port WDSel  output  2  register write-data select: 00 ALU result, 01 memory data, 10 PC+4.
REQ-015 The block SHALL have port GPRSel  output  2  destination register select: 00 rd, 01 rt, 10 $31.
REQ-016 The block SHALL have port NPCOp  output  2  next-PC select: 00 PC+4, 01 branch, 10 jump.
REQ-017 The block SHALL have port state  output  ST_W  current FSM state, for debug.
REQ-018 The block SHALL have port instr_done  output  1  one-cycle pulse in the final cycle of every instruction.
REQ-019 The block SHALL have port illegal  output  1  one-cycle pulse when an unsupported opcode or funct is decoded.

Function
REQ-020 The FSM SHALL have states FETCH=0, DCD=1, EXE=2, MADR=3, MRD=4, MWB=5, MWR=6, AWB=7, BR=8, JMP=9; codes 10-15 SHALL go to FETCH on the next edge.
REQ-021 Outputs SHALL be Moore-decoded from state and Op; Zero SHALL be the only Mealy input, used in BR only.
REQ-022 FETCH SHALL assert IRWr=1 and PCWr=1 with NPCOp=00, then go to DCD.
REQ-023 DCD SHALL decode Op/Funct and transition: R-type, addi, addiu, ori, lui -> EXE; lw, sw -> MADR; beq -> BR; j, jal -> JMP; anything else -> FETCH with illegal=1.
REQ-024 EXE SHALL drive ALUOp from Funct (addu 100001, subu 100011, and 100100, or 100101, slt 101010) for R-type, add for addi/addiu/lui, and or for ori, then go to AWB.
REQ-025 EXE SHALL set BSel=1 for I-type and BSel=0 for R-type.
REQ-026 ExtOp SHALL be 01 for addi, addiu, lw, sw, and beq; 00 for ori; and 10 for lui.
REQ-027 ExtOp SHALL be held stable from DCD through the last state of the instruction.
REQ-028 ExtOp SHALL be 00 in FETCH, and in every state of an instruction not listed in REQ-026.
REQ-029 AWB SHALL assert RFWr=1 and WDSel=00, with GPRSel=00 for R-type and 01 otherwise, plus instr_done=1, then go to FETCH.
REQ-030 MADR SHALL assert ALUOp=000 and BSel=1, then go to MRD for lw or MWR for sw.
REQ-031 MRD SHALL go to MWB.
REQ-032 MWB SHALL assert RFWr=1, WDSel=01, GPRSel=01 and instr_done=1, then go to FETCH.
REQ-033 MWR SHALL assert DMWr=1 and instr_done=1, then go to FETCH.
REQ-034 BR SHALL assert ALUOp=001, BSel=0, NPCOp=01, PCWr=Zero and instr_done=1, then go to FETCH.
REQ-035 JMP SHALL assert PCWr=1 and NPCOp=10; for jal it SHALL also assert RFWr=1, WDSel=10 and GPRSel=10; it SHALL assert instr_done=1 and go to FETCH.
REQ-036 Instruction latencies in cycles SHALL be: R/I-ALU 4, lw 5, sw 4, beq 3, j/jal 3.
REQ-037 An illegal opcode SHALL cost 2 cycles and cause no RFWr or DMWr.
REQ-038 PCWr, RFWr and DMWr SHALL never be asserted in the same cycle as each other, except PCWr with RFWr in JMP for jal.
REQ-039 Op and Funct changes outside DCD/EXE SHALL NOT alter the state sequence, because the instruction register is stable after FETCH.

Reset
REQ-040 rstn=0 SHALL immediately force state=FETCH and force all enables, ExtOp, ALUOp, BSel, WDSel, GPRSel, NPCOp, instr_done and illegal to 0, independent of clk.
REQ-041 After rstn rises, the first rising clk edge SHALL perform a FETCH.
REQ-042 Reset asserted mid-instruction (e.g. in MWR) SHALL abort it with no write pulse completing after the reset edge.

Verification
REQ-043 The bench SHALL check: reset, then Op=000000, Funct=100001 -> states 0,1,2,7; RFWr=1 only in cycle 4 with GPRSel=00; instr_done pulses once.
REQ-044 The bench SHALL check: Op=001101 (ori) -> ExtOp=00 in DCD/EXE/AWB, ALUOp=011, BSel=1, GPRSel=01.
REQ-045 The bench SHALL check: Op=001111 (lui) -> ExtOp=10 and ALUOp=000; lw (100011) -> ExtOp=01, states 0,1,3,4,5, RFWr in cycle 5 with WDSel=01.
REQ-046 The bench SHALL check: beq (000100) with Zero=1 -> PCWr=1 and NPCOp=01 in cycle 3; with Zero=0 -> PCWr=0 in cycle 3; jal (000011) -> RFWr=1, PCWr=1, GPRSel=10, WDSel=10 in cycle 3.
REQ-047 The bench SHALL check: Op=111111 -> illegal=1 in DCD, state returns to 0 with no RFWr/DMWr.
REQ-048 The bench SHALL check: rstn pulsed low while in MWR for sw -> DMWr falls asynchronously and state=0.
